// File: rtl/vga_pkg.sv
// Frame-buffer geometry and types shared by the VGA read side and the camera capture side.
// Default timing is 640x480@60 from a 25 MHz pixel clock.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int FB_ADDR_W = 19;
  localparam int FB_DATA_W = 8;
  localparam int FB_PIXELS = H_ACTIVE * V_ACTIVE;

  // Wide enough for both 800 clocks/line and 525 lines/frame.
  localparam int CNT_W = 10;

  typedef logic [FB_ADDR_W-1:0] fb_addr_t;
  typedef logic [FB_DATA_W-1:0] fb_data_t;
  typedef logic [CNT_W-1:0]     cnt_t;

  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } vid_ctl_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical raster counters with registered active, sync and frame markers.
// Markers describe the counter position of the previous clock, so they form the aligned timing domain.
module vga_timing_gen #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP
) (
  input  logic clk,
  input  logic rst,
  output logic active,
  output logic hs,
  output logic vs,
  output logic frame_start,
  output logic frame_last
);

  localparam vga_pkg::cnt_t H_ACT = vga_pkg::cnt_t'(H_ACTIVE);
  localparam vga_pkg::cnt_t H_SS  = vga_pkg::cnt_t'(H_ACTIVE + H_FP);
  localparam vga_pkg::cnt_t H_SE  = vga_pkg::cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam vga_pkg::cnt_t H_END = vga_pkg::cnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam vga_pkg::cnt_t V_ACT = vga_pkg::cnt_t'(V_ACTIVE);
  localparam vga_pkg::cnt_t V_SS  = vga_pkg::cnt_t'(V_ACTIVE + V_FP);
  localparam vga_pkg::cnt_t V_SE  = vga_pkg::cnt_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam vga_pkg::cnt_t V_END = vga_pkg::cnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam vga_pkg::cnt_t ONE   = vga_pkg::cnt_t'(1);

  vga_pkg::cnt_t h_cnt;
  vga_pkg::cnt_t v_cnt;

  // The counters run one clock ahead of the markers; after reset release the first
  // clock therefore presents position (0,0) on the markers.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      active      <= 1'b0;
      hs          <= 1'b0;
      vs          <= 1'b0;
      frame_start <= 1'b0;
      frame_last  <= 1'b0;
    end else begin
      active      <= (h_cnt < H_ACT) && (v_cnt < V_ACT);
      hs          <= (h_cnt >= H_SS) && (h_cnt < H_SE);
      vs          <= (v_cnt >= V_SS) && (v_cnt < V_SE);
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
      frame_last  <= (h_cnt == H_END) && (v_cnt == V_END);
      if (h_cnt == H_END) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_END) ? '0 : v_cnt + ONE;
      end else begin
        h_cnt <= h_cnt + ONE;
      end
    end
  end

endmodule

// File: rtl/vga_framebuffer_reader.sv
// Frame RAM read side: raster timing, sequential pixel addressing, and sync/colour
// re-alignment to the RAM read latency so syncs and pixels leave the pins RD_LAT+1 clocks after timing.
module vga_framebuffer_reader #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP,
  parameter int RD_LAT   = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [18:0] rd_addr,
  output logic        rd_en,
  input  logic [7:0]  rd_data,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        frame_start
);

  logic active;
  logic hs_on;
  logic vs_on;
  logic frame_last;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .active      (active),
    .hs          (hs_on),
    .vs          (vs_on),
    .frame_start (frame_start),
    .frame_last  (frame_last)
  );

  assign rd_en = active;

  // Address advances only past active pixels, so it parks one past the last pixel
  // through vertical blanking and is rewound on the final clock of the frame.
  always_ff @(posedge clk) begin
    if (rst || frame_last) begin
      rd_addr <= '0;
    end else if (active) begin
      rd_addr <= rd_addr + 19'd1;
    end
  end

  vga_pkg::vid_ctl_t dly [RD_LAT];
  vga_pkg::vid_ctl_t tail;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        dly[i] <= '0;
      end
    end else begin
      dly[0] <= '{active: active, hs: hs_on, vs: vs_on};
      for (int i = 1; i < RD_LAT; i++) begin
        dly[i] <= dly[i-1];
      end
    end
  end

  assign tail = dly[RD_LAT-1];

  logic [3:0] luma_hi;
  logic       unused_luma_lo;

  // Only the top nibble of luma reaches the 4-bit DAC; grey is driven on all three guns.
  assign luma_hi        = rd_data[7:4];
  assign unused_luma_lo = ^rd_data[3:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
    end else begin
      vga_hs <= ~tail.hs;
      vga_vs <= ~tail.vs;
      vga_r  <= tail.active ? luma_hi : 4'h0;
      vga_g  <= tail.active ? luma_hi : 4'h0;
      vga_b  <= tail.active ? luma_hi : 4'h0;
    end
  end

endmodule

// File: tb/tb_vga_framebuffer_reader.sv
// Self-checking bench: two full-size readers (RD_LAT 1 and 3) plus a tiny-raster reader
// for whole-frame behaviour, all compared against a position-arithmetic reference model.
module tb_vga_framebuffer_reader;

  typedef struct packed {
    int ha; int hf; int hsw; int hb;
    int va; int vf; int vsw; int vb;
    int lat;
  } geom_t;

  localparam geom_t G1 = '{ha:640, hf:16, hsw:96, hb:48, va:480, vf:10, vsw:2, vb:33, lat:1};
  localparam geom_t G3 = '{ha:640, hf:16, hsw:96, hb:48, va:480, vf:10, vsw:2, vb:33, lat:3};
  localparam geom_t GS = '{ha:8,   hf:2,  hsw:3,  hb:2,  va:4,   vf:1,  vsw:2, vb:1,  lat:2};
  localparam logic [34:0] RESET_VEC = {1'b0, 19'd0, 1'b0, 1'b1, 1'b1, 12'h000};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #20 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mode = 0;
  logic [7:0] salt = 8'h00;

  logic [18:0] a1_rd_addr, a3_rd_addr, s_rd_addr;
  logic        a1_rd_en, a3_rd_en, s_rd_en;
  logic [7:0]  a1_rd_data, a3_rd_data, s_rd_data;
  logic        a1_hs, a3_hs, s_hs, a1_vs, a3_vs, s_vs;
  logic [3:0]  a1_r, a1_g, a1_b, a3_r, a3_g, a3_b, s_r, s_g, s_b;
  logic        a1_fs, a3_fs, s_fs;

  vga_framebuffer_reader #(.RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .rd_addr(a1_rd_addr), .rd_en(a1_rd_en), .rd_data(a1_rd_data),
    .vga_hs(a1_hs), .vga_vs(a1_vs), .vga_r(a1_r), .vga_g(a1_g), .vga_b(a1_b), .frame_start(a1_fs));

  vga_framebuffer_reader #(.RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .rd_addr(a3_rd_addr), .rd_en(a3_rd_en), .rd_data(a3_rd_data),
    .vga_hs(a3_hs), .vga_vs(a3_vs), .vga_r(a3_r), .vga_g(a3_g), .vga_b(a3_b), .frame_start(a3_fs));

  vga_framebuffer_reader #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .RD_LAT(2)
  ) duts (
    .clk(clk), .rst(rst), .rd_addr(s_rd_addr), .rd_en(s_rd_en), .rd_data(s_rd_data),
    .vga_hs(s_hs), .vga_vs(s_vs), .vga_r(s_r), .vga_g(s_g), .vga_b(s_b), .frame_start(s_fs));

  wire [34:0] v1 = {a1_rd_en, a1_rd_addr, a1_fs, a1_hs, a1_vs, a1_r, a1_g, a1_b};
  wire [34:0] v3 = {a3_rd_en, a3_rd_addr, a3_fs, a3_hs, a3_vs, a3_r, a3_g, a3_b};
  wire [34:0] vs = {s_rd_en, s_rd_addr, s_fs, s_hs, s_vs, s_r, s_g, s_b};

  // Frame RAM contents as a function of address; the RAM drives junk 0xFF when not read.
  function automatic logic [7:0] ram_byte(int md, logic [7:0] sl, int addr);
    logic [31:0] a;
    logic [7:0]  m;
    a = addr;
    m = a[7:0] * 8'd29;
    case (md)
      0:       return a[7:0];
      1:       return 8'hFF;
      default: return m ^ a[15:8] ^ sl;
    endcase
  endfunction

  logic [7:0] ram1_q;
  logic [7:0] ram3_q [3];
  logic [7:0] rams_q [2];

  always @(posedge clk) begin
    ram1_q    <= a1_rd_en ? ram_byte(mode, salt, int'(a1_rd_addr)) : 8'hFF;
    ram3_q[0] <= a3_rd_en ? ram_byte(mode, salt, int'(a3_rd_addr)) : 8'hFF;
    ram3_q[1] <= ram3_q[0];
    ram3_q[2] <= ram3_q[1];
    rams_q[0] <= s_rd_en ? ram_byte(mode, salt, int'(s_rd_addr)) : 8'hFF;
    rams_q[1] <= rams_q[0];
  end

  assign a1_rd_data = ram1_q;
  assign a3_rd_data = ram3_q[2];
  assign s_rd_data  = rams_q[1];

  // Expected outputs i clocks after reset release, from raster position arithmetic.
  function automatic logic [34:0] m_vec(geom_t g, int i, int md, logic [7:0] sl);
    int ht, vt, p, h, v, addr, p2, h2, v2;
    logic act, fs, hs, vsy;
    logic [3:0] c;
    logic [7:0] b;
    ht = g.ha + g.hf + g.hsw + g.hb;
    vt = g.va + g.vf + g.vsw + g.vb;
    p = i % (ht * vt);
    h = p % ht;
    v = p / ht;
    act  = (h < g.ha) && (v < g.va);
    addr = (v < g.va) ? v * g.ha + ((h < g.ha) ? h : g.ha) : g.ha * g.va;
    fs   = (p == 0);
    hs = 1'b1; vsy = 1'b1; c = 4'h0; b = 8'h00;
    if (i - g.lat - 1 >= 0) begin
      p2 = (i - g.lat - 1) % (ht * vt);
      h2 = p2 % ht;
      v2 = p2 / ht;
      hs  = !(h2 >= g.ha + g.hf && h2 < g.ha + g.hf + g.hsw);
      vsy = !(v2 >= g.va + g.vf && v2 < g.va + g.vf + g.vsw);
      if (h2 < g.ha && v2 < g.va) begin
        b = ram_byte(md, sl, v2 * g.ha + h2);
        c = b[7:4];
      end
    end
    return {act, addr[18:0], fs, hs, vsy, c, c, c};
  endfunction

  task automatic do_reset(int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset(5);
    checks++; if (v1 !== RESET_VEC) begin errors++; $display("FAIL reset_lat1: got %h expected %h", v1, RESET_VEC); end
    checks++; if (v3 !== RESET_VEC) begin errors++; $display("FAIL reset_lat3: got %h expected %h", v3, RESET_VEC); end
    checks++; if (vs !== RESET_VEC) begin errors++; $display("FAIL reset_small: got %h expected %h", vs, RESET_VEC); end
  endtask

  task automatic test_hsync();
    int fall1 [2];
    int rise1 [2];
    int fall2 [2];
    logic prev [2];
    logic cur;
    mode = 0;
    do_reset(2);
    rst = 1'b0;
    for (int j = 0; j < 2; j++) begin fall1[j] = -1; rise1[j] = -1; fall2[j] = -1; prev[j] = 1'b1; end
    for (int i = 0; i < 1800; i++) begin
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        cur = (j == 0) ? a1_hs : a3_hs;
        if (prev[j] && !cur) begin
          if (fall1[j] < 0) fall1[j] = i;
          else if (fall2[j] < 0) fall2[j] = i;
        end
        if (!prev[j] && cur && rise1[j] < 0) rise1[j] = i;
        prev[j] = cur;
      end
    end
    for (int j = 0; j < 2; j++) begin
      int lat;
      lat = (j == 0) ? 1 : 3;
      checks++; if (fall1[j] != 656 + lat + 1) begin errors++; $display("FAIL hs_first_fall lat%0d: got %0d expected %0d", lat, fall1[j], 656 + lat + 1); end
      checks++; if (rise1[j] - fall1[j] != 96) begin errors++; $display("FAIL hs_low_width lat%0d: got %0d expected 96", lat, rise1[j] - fall1[j]); end
      checks++; if (fall2[j] - fall1[j] != 800) begin errors++; $display("FAIL hs_period lat%0d: got %0d expected 800", lat, fall2[j] - fall1[j]); end
    end
  endtask

  task automatic test_pixels();
    logic [34:0] e1, e3;
    mode = 0;
    do_reset(2);
    rst = 1'b0;
    for (int i = 0; i < 1620; i++) begin
      @(negedge clk);
      e1 = m_vec(G1, i, mode, salt);
      e3 = m_vec(G3, i, mode, salt);
      checks++; if (v1 !== e1) begin errors++; $display("FAIL pix_vec_lat1 @%0d: got %h expected %h", i, v1, e1); end
      checks++; if (v3 !== e3) begin errors++; $display("FAIL pix_vec_lat3 @%0d: got %h expected %h", i, v3, e3); end
      if (i == 1605) begin
        checks++; if ({a1_rd_en, a1_rd_addr} !== {1'b1, 19'd1285}) begin errors++; $display("FAIL pix_5_2_addr_lat1: got %0d en %b expected 1285", a1_rd_addr, a1_rd_en); end
        checks++; if ({a3_rd_en, a3_rd_addr} !== {1'b1, 19'd1285}) begin errors++; $display("FAIL pix_5_2_addr_lat3: got %0d en %b expected 1285", a3_rd_addr, a3_rd_en); end
      end
      if (i == 1605 + 2) begin
        checks++; if (a1_r !== 4'h0) begin errors++; $display("FAIL pix_5_2_red_lat1: got %h expected 0", a1_r); end
      end
      if (i == 1605 + 4) begin
        checks++; if (a3_r !== 4'h0) begin errors++; $display("FAIL pix_5_2_red_lat3: got %h expected 0", a3_r); end
      end
      if (i == 63 + 2) begin
        checks++; if ({a1_r, a1_g, a1_b} !== 12'h333) begin errors++; $display("FAIL pix_3f_lat1: got %h expected 333", {a1_r, a1_g, a1_b}); end
      end
      if (i == 63 + 4) begin
        checks++; if ({a3_r, a3_g, a3_b} !== 12'h333) begin errors++; $display("FAIL pix_3f_lat3: got %h expected 333", {a3_r, a3_g, a3_b}); end
      end
    end
  endtask

  task automatic test_blanking();
    int k2, lat;
    logic [11:0] got, exp;
    mode = 1;
    do_reset(2);
    rst = 1'b0;
    for (int i = 0; i < 1700; i++) begin
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        lat = (j == 0) ? 1 : 3;
        got = (j == 0) ? {a1_r, a1_g, a1_b} : {a3_r, a3_g, a3_b};
        k2  = i - lat - 1;
        exp = (k2 >= 0 && (k2 % 800) < 640 && (k2 / 800) < 480) ? 12'hFFF : 12'h000;
        checks++; if (got !== exp) begin errors++; $display("FAIL blank_rgb lat%0d @%0d: got %h expected %h", lat, i, got, exp); end
      end
    end
  endtask

  task automatic test_small_frames();
    int cnt [3];
    int max_addr, fs_first, fs_second, vs_fall1, vs_rise1, vs_fall2;
    logic prev_vs;
    logic [34:0] e;
    mode = 2;
    salt = 8'($urandom);
    do_reset(2);
    rst = 1'b0;
    for (int f = 0; f < 3; f++) cnt[f] = 0;
    max_addr = -1; fs_first = -1; fs_second = -1;
    vs_fall1 = -1; vs_rise1 = -1; vs_fall2 = -1; prev_vs = 1'b1;
    for (int i = 0; i < 3 * 120 + 5; i++) begin
      @(negedge clk);
      e = m_vec(GS, i, mode, salt);
      checks++; if (vs !== e) begin errors++; $display("FAIL small_vec @%0d: got %h expected %h", i, vs, e); end
      if (s_rd_en === 1'b1) begin
        if (i / 120 < 3) cnt[i / 120]++;
        if (int'(s_rd_addr) > max_addr) max_addr = int'(s_rd_addr);
      end
      if (s_fs === 1'b1) begin
        checks++; if (s_rd_addr !== 19'd0) begin errors++; $display("FAIL small_addr_at_fs @%0d: got %0d expected 0", i, s_rd_addr); end
        if (fs_first < 0) fs_first = i; else if (fs_second < 0) fs_second = i;
      end
      if (prev_vs && !s_vs) begin
        if (vs_fall1 < 0) vs_fall1 = i; else if (vs_fall2 < 0) vs_fall2 = i;
      end
      if (!prev_vs && s_vs && vs_rise1 < 0) vs_rise1 = i;
      prev_vs = s_vs;
    end
    for (int f = 0; f < 3; f++) begin
      checks++; if (cnt[f] != 32) begin errors++; $display("FAIL small_rd_en_count frame%0d: got %0d expected 32", f, cnt[f]); end
    end
    checks++; if (max_addr != 31) begin errors++; $display("FAIL small_max_addr: got %0d expected 31", max_addr); end
    checks++; if (fs_second - fs_first != 120) begin errors++; $display("FAIL small_fs_period: got %0d expected 120", fs_second - fs_first); end
    checks++; if (vs_fall1 != 5 * 15 + 3) begin errors++; $display("FAIL small_vs_first_fall: got %0d expected 78", vs_fall1); end
    checks++; if (vs_rise1 - vs_fall1 != 30) begin errors++; $display("FAIL small_vs_width: got %0d expected 30", vs_rise1 - vs_fall1); end
    checks++; if (vs_fall2 - vs_fall1 != 120) begin errors++; $display("FAIL small_vs_period: got %0d expected 120", vs_fall2 - vs_fall1); end
  endtask

  task automatic test_midframe_reset();
    logic [34:0] e1, e3, es;
    int hs_fall;
    logic prev_hs;
    mode = 2;
    salt = 8'($urandom);
    do_reset(2);
    rst = 1'b0;
    // Runs until the full-size raster sits at h=300, v=2.
    for (int i = 0; i <= 1900; i++) begin
      @(negedge clk);
      e1 = m_vec(G1, i, mode, salt);
      es = m_vec(GS, i, mode, salt);
      checks++; if (v1 !== e1) begin errors++; $display("FAIL pre_rst_vec_lat1 @%0d: got %h expected %h", i, v1, e1); end
      checks++; if (vs !== es) begin errors++; $display("FAIL pre_rst_vec_small @%0d: got %h expected %h", i, vs, es); end
    end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (v1 !== RESET_VEC) begin errors++; $display("FAIL midrst_lat1: got %h expected %h", v1, RESET_VEC); end
    checks++; if (v3 !== RESET_VEC) begin errors++; $display("FAIL midrst_lat3: got %h expected %h", v3, RESET_VEC); end
    checks++; if (vs !== RESET_VEC) begin errors++; $display("FAIL midrst_small: got %h expected %h", vs, RESET_VEC); end
    rst = 1'b0;
    hs_fall = -1;
    prev_hs = 1'b1;
    for (int i = 0; i < 1700; i++) begin
      @(negedge clk);
      e1 = m_vec(G1, i, mode, salt);
      e3 = m_vec(G3, i, mode, salt);
      es = m_vec(GS, i, mode, salt);
      checks++; if (v1 !== e1) begin errors++; $display("FAIL post_rst_vec_lat1 @%0d: got %h expected %h", i, v1, e1); end
      checks++; if (v3 !== e3) begin errors++; $display("FAIL post_rst_vec_lat3 @%0d: got %h expected %h", i, v3, e3); end
      checks++; if (vs !== es) begin errors++; $display("FAIL post_rst_vec_small @%0d: got %h expected %h", i, vs, es); end
      if (prev_hs && !a1_hs && hs_fall < 0) hs_fall = i;
      prev_hs = a1_hs;
    end
    checks++; if (hs_fall != 658) begin errors++; $display("FAIL post_rst_hs_fall: got %0d expected 658", hs_fall); end
  endtask

  initial begin
    test_reset();
    test_hsync();
    test_pixels();
    test_blanking();
    test_small_frames();
    test_midframe_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
